// File: rtl/qspi_ctrl_pkg.sv
// Shared state encoding and protocol constants for the
// quad-SPI ROM read controller.
package qspi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_STREAM,
      ST_DESEL
   } state_t;

   localparam logic [7:0] CMD_OPCODE = 8'hEB;
   localparam int         CMD_LEN    = 8;
   localparam logic [3:0] IO_IDLE    = 4'h0;

   // Opcode goes out one bit per cycle on IO0 with IO3/IO2 held high.
   function automatic logic [3:0] cmd_nibble(input logic b);
      return {3'b110, b};
   endfunction

endpackage

// File: rtl/qspi_prefetch_buf.sv
// One-entry prefetch buffer: remembers the most recently streamed
// byte and flags a request that matches it.
module qspi_prefetch_buf
   import qspi_ctrl_pkg::*;
#(
   parameter int ADDR_BITS = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [7:0]           load_data,
   input  logic [ADDR_BITS-1:0] lookup_addr,
   output logic                 hit,
   output logic [7:0]           data
);

   logic [ADDR_BITS-1:0] last_addr;
   logic [7:0]           last_data;
   logic                 last_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_addr  <= '0;
         last_data  <= '0;
         last_valid <= 1'b0;
      end else if (load) begin
         last_addr  <= load_addr;
         last_data  <= load_data;
         last_valid <= 1'b1;
      end
   end

   assign hit  = last_valid && (lookup_addr == last_addr);
   assign data = last_data;

endmodule

// File: rtl/qspi_rom_ctrl.sv
// Quad-SPI ROM read controller: issues 0xEB fast-read bursts and keeps
// streaming sequential bytes while requests follow the stream.
module qspi_rom_ctrl
   import qspi_ctrl_pkg::*;
#(
   parameter int ADDR_BITS    = 24,
   parameter int DUMMY_CYCLES = 6,
   parameter int IDLE_BYTES   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic [ADDR_BITS-1:0] addr,
   output logic [7:0]           rdata,
   output logic                 rdata_valid,
   output logic                 qspi_cs_n,
   output logic [3:0]           qspi_io_out,
   output logic                 qspi_io_oe,
   input  logic [3:0]           qspi_io_in
);

   localparam logic [7:0] CMD_LAST   = 8'(CMD_LEN - 1);
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
   localparam logic [7:0] IDLE_LAST  = 8'(IDLE_BYTES - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

   state_t               state;
   logic [7:0]           cnt;
   logic [7:0]           idle_cnt;
   logic [7:0]           op_sh;
   logic                 phase;
   logic [3:0]           hi_nib;
   logic [ADDR_BITS-1:0] addr_sh;
   logic [ADDR_BITS-1:0] b_addr;

   logic       buf_hit;
   logic [7:0] buf_data;
   logic [7:0] new_byte;
   logic       req_live;
   logic       byte_done;
   logic       buf_deliver;
   logic       stream_hit;
   logic       abort;
   logic       idle_tick;
   logic       idle_full;
   logic       start;

   // The request that was just answered is still on the bus this cycle.
   assign req_live    = req && !rdata_valid;
   assign byte_done   = (state == ST_STREAM) && phase;
   assign new_byte    = {hi_nib, qspi_io_in};
   assign buf_deliver = req_live && buf_hit;
   assign stream_hit  = byte_done && req_live && !buf_hit
                        && (addr == b_addr);
   assign abort       = byte_done && req_live && !buf_hit
                        && (addr != b_addr);
   assign idle_tick   = byte_done && !req_live;
   assign idle_full   = idle_tick && (idle_cnt == IDLE_LAST);
   assign start       = ((state == ST_IDLE) || (state == ST_DESEL))
                        && req_live && !buf_hit;

   qspi_prefetch_buf #(
      .ADDR_BITS(ADDR_BITS)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .load       (byte_done),
      .load_addr  (b_addr),
      .load_data  (new_byte),
      .lookup_addr(addr),
      .hit        (buf_hit),
      .data       (buf_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idle_cnt    <= '0;
         op_sh       <= '0;
         phase       <= 1'b0;
         hi_nib      <= '0;
         addr_sh     <= '0;
         b_addr      <= '0;
         qspi_cs_n   <= 1'b1;
         qspi_io_out <= IO_IDLE;
         qspi_io_oe  <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         if (buf_deliver) begin
            rdata       <= buf_data;
            rdata_valid <= 1'b1;
         end else if (stream_hit) begin
            rdata       <= new_byte;
            rdata_valid <= 1'b1;
         end

         if (buf_deliver || stream_hit) begin
            idle_cnt <= '0;
         end else if (idle_tick) begin
            idle_cnt <= idle_full ? '0 : idle_cnt + 8'd1;
         end

         unique case (state)
            ST_IDLE, ST_DESEL: begin
               if (start) begin
                  state       <= ST_CMD;
                  cnt         <= '0;
                  idle_cnt    <= '0;
                  op_sh       <= {CMD_OPCODE[6:0], 1'b0};
                  addr_sh     <= addr;
                  b_addr      <= addr;
                  qspi_cs_n   <= 1'b0;
                  qspi_io_out <= cmd_nibble(CMD_OPCODE[7]);
                  qspi_io_oe  <= 1'b1;
               end else begin
                  state       <= ST_IDLE;
                  qspi_cs_n   <= 1'b1;
                  qspi_io_out <= IO_IDLE;
                  qspi_io_oe  <= 1'b0;
               end
            end
            ST_CMD: begin
               cnt         <= cnt + 8'd1;
               qspi_io_out <= cmd_nibble(op_sh[7]);
               op_sh       <= {op_sh[6:0], 1'b0};
               if (cnt == CMD_LAST) begin
                  state       <= ST_ADDR;
                  cnt         <= '0;
                  qspi_io_out <= addr_sh[ADDR_BITS-1 -: 4];
                  addr_sh     <= addr_sh << 4;
               end
            end
            ST_ADDR: begin
               cnt         <= cnt + 8'd1;
               qspi_io_out <= addr_sh[ADDR_BITS-1 -: 4];
               addr_sh     <= addr_sh << 4;
               if (cnt == ADDR_LAST) begin
                  state       <= ST_DUMMY;
                  cnt         <= '0;
                  qspi_io_out <= IO_IDLE;
                  qspi_io_oe  <= 1'b0;
               end
            end
            ST_DUMMY: begin
               cnt <= cnt + 8'd1;
               if (cnt == DUMMY_LAST) begin
                  state <= ST_STREAM;
                  cnt   <= '0;
                  phase <= 1'b0;
               end
            end
            ST_STREAM: begin
               phase <= !phase;
               if (!phase) begin
                  hi_nib <= qspi_io_in;
               end else begin
                  b_addr <= b_addr + ADDR_ONE;
                  if (abort || idle_full) begin
                     state     <= ST_DESEL;
                     qspi_cs_n <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_rom_ctrl.sv
// Directed and randomized bench: controller paired with a behavioural
// quad-SPI ROM; every returned byte is checked against the ROM contents.
`timescale 1ns/1ps
module tb_qspi_rom_ctrl;

   localparam int AB = 24;
   localparam logic [7:0] OPC = 8'hEB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req = 1'b0;
   logic [AB-1:0] addr = '0;
   logic [7:0]    rdata;
   logic          rdata_valid;
   logic          qspi_cs_n;
   logic [3:0]    qspi_io_out;
   logic          qspi_io_oe;
   logic [3:0]    qspi_io_in = '0;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   qspi_rom_ctrl #(
      .ADDR_BITS(AB),
      .DUMMY_CYCLES(6),
      .IDLE_BYTES(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .addr       (addr),
      .rdata      (rdata),
      .rdata_valid(rdata_valid),
      .qspi_cs_n  (qspi_cs_n),
      .qspi_io_out(qspi_io_out),
      .qspi_io_oe (qspi_io_oe),
      .qspi_io_in (qspi_io_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rom_byte(input logic [AB-1:0] a);
      logic [31:0] h;
      if (a == 24'h000FFC) return 8'h00;
      if (a == 24'h000FFD) return 8'hF0;
      h = 32'(a) * 32'h9E3779B1;
      return h[23:16] ^ a[7:0];
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, got, exp, cyc);
      end
   endtask

   // ROM model and per-cycle output checks, sampled mid-cycle.
   int            k = 0;
   int            idx;
   logic [7:0]    b;
   logic [AB-1:0] dec_addr = '0;
   logic [AB-1:0] start_addr = '0;
   logic [AB-1:0] prev_addr = '0;
   logic          prev_req = 1'b0;
   logic          prev_valid = 1'b0;
   logic          prev_cs = 1'b1;
   int            falls = 0;
   int            rises = 0;
   int            fall_cyc = 0;
   int            rise_cyc = 0;
   int            hi_len = 0;
   int            last_hi_len = 0;

   always @(negedge clk) begin
      if (reset) begin
         k       = 0;
         prev_cs = 1'b1;
         hi_len  = 0;
      end else begin
         if (rdata_valid) begin
            check("valid_has_req", 32'(prev_req), 32'd1);
            check("valid_not_b2b", 32'(prev_valid), 32'd0);
            check("rdata", 32'(rdata), 32'(rom_byte(prev_addr)));
         end
         if (qspi_cs_n) begin
            check("desel_oe", 32'(qspi_io_oe), 32'd0);
            check("desel_io", 32'(qspi_io_out), 32'd0);
            if (!prev_cs) begin
               rises++;
               rise_cyc = cyc;
               hi_len = 0;
            end
            hi_len++;
            k = 0;
         end else begin
            if (prev_cs) begin
               falls++;
               fall_cyc = cyc;
               last_hi_len = hi_len;
               start_addr = prev_addr;
            end
            if (k < 8) begin
               check("cmd_oe", 32'(qspi_io_oe), 32'd1);
               check("cmd_bit", 32'(qspi_io_out),
                     32'({3'b110, OPC[7-k]}));
            end else if (k < 14) begin
               check("addr_oe", 32'(qspi_io_oe), 32'd1);
               dec_addr = {dec_addr[AB-5:0], qspi_io_out};
               if (k == 13)
                  check("addr_nibbles", 32'(dec_addr), 32'(start_addr));
            end else begin
               check("rx_oe", 32'(qspi_io_oe), 32'd0);
               if (k < 20)
                  check("dummy_io", 32'(qspi_io_out), 32'd0);
            end
            if (k >= 20) begin
               idx = (k - 20) / 2;
               b = rom_byte(dec_addr + idx[AB-1:0]);
               qspi_io_in = (k % 2 == 0) ? b[7:4] : b[3:0];
            end else begin
               qspi_io_in = 4'($urandom);
            end
            k++;
         end
         prev_cs = qspi_cs_n;
      end
      prev_valid = rdata_valid;
      prev_req   = req;
      prev_addr  = addr;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Present a request and wait (bounded) for its rdata_valid cycle.
   task automatic issue(input logic [AB-1:0] a, output int lat);
      req  = 1'b1;
      addr = a;
      lat  = 0;
      do begin
         step();
         lat++;
      end while (!rdata_valid && lat < 150);
      check("req_done", 32'(rdata_valid), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat;
      int            c0;
      int            r0;
      int            f0;
      int            v;
      logic [AB-1:0] na;
      logic [AB-1:0] pa;

      repeat (3) step();
      check("rst_cs_n", 32'(qspi_cs_n), 32'd1);
      check("rst_oe", 32'(qspi_io_oe), 32'd0);
      check("rst_io", 32'(qspi_io_out), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_valid", 32'(rdata_valid), 32'd0);
      reset = 1'b0;
      step();

      // Cold read of 0xFFC
      c0 = cyc;
      issue(24'h000FFC, lat);
      check("s1_latency", 32'(lat), 32'd23);
      check("s1_cs_fall", 32'(fall_cyc), 32'(c0 + 1));
      check("s1_addr", 32'(dec_addr), 32'h000FFC);
      check("s1_rdata", 32'(rdata), 32'h00);

      // Next sequential byte out of the running stream
      r0 = rises;
      issue(24'h000FFD, lat);
      check("s2_lat_le2", 32'(lat <= 2), 32'd1);
      check("s2_rdata", 32'(rdata), 32'hF0);
      check("s2_no_desel", 32'(rises), 32'(r0));

      // Repeat request served by the prefetch buffer
      issue(24'h000FFD, lat);
      check("s3_lat", 32'(lat), 32'd2);
      check("s3_rdata", 32'(rdata), 32'hF0);
      check("s3_no_desel", 32'(rises), 32'(r0));

      // Out-of-stream request aborts and restarts the burst
      f0 = falls;
      issue(24'h000100, lat);
      check("s4_lat", 32'(lat), 32'd25);
      check("s4_rises", 32'(rises), 32'(r0 + 1));
      check("s4_falls", 32'(falls), 32'(f0 + 1));
      check("s4_desel_len", 32'(last_hi_len), 32'd1);
      check("s4_addr", 32'(dec_addr), 32'h000100);
      check("s4_rdata", 32'(rdata), 32'(rom_byte(24'h000100)));

      // Idle stream deselects after four unrequested bytes
      v  = cyc;
      r0 = rises;
      req = 1'b0;
      c0 = 0;
      while (rises == r0 && c0 < 40) begin
         step();
         c0++;
      end
      check("s5_desel_cycle", 32'(rise_cyc), 32'(v + 8));
      f0 = falls;
      repeat (5) step();
      check("s5_idle_cs", 32'(qspi_cs_n), 32'd1);
      check("s5_idle_falls", 32'(falls), 32'(f0));

      // Buffer still holds the last streamed byte while idle
      issue(24'h000104, lat);
      check("s6_lat", 32'(lat), 32'd1);
      check("s6_rdata", 32'(rdata), 32'(rom_byte(24'h000104)));
      check("s6_no_cmd", 32'(falls), 32'(f0));

      // Reset in the middle of the address phase
      req  = 1'b1;
      addr = 24'h12345A;
      c0 = 0;
      while (!(k >= 10 && !qspi_cs_n) && c0 < 60) begin
         step();
         c0++;
      end
      check("s7_in_addr", 32'(k >= 10 && k < 14), 32'd1);
      reset = 1'b1;
      req   = 1'b0;
      step();
      check("s7_cs_n", 32'(qspi_cs_n), 32'd1);
      check("s7_valid", 32'(rdata_valid), 32'd0);
      check("s7_oe", 32'(qspi_io_oe), 32'd0);
      check("s7_io", 32'(qspi_io_out), 32'd0);
      check("s7_rdata", 32'(rdata), 32'd0);
      reset = 1'b0;
      step();
      f0 = falls;
      issue(24'h000104, lat);
      check("s7_full_lat", 32'(lat), 32'd23);
      check("s7_new_cmd", 32'(falls), 32'(f0 + 1));

      // Stream wraps from the top of the address space
      issue(24'hFFFFFE, lat);
      f0 = falls;
      issue(24'hFFFFFF, lat);
      check("s8_lat_ff", 32'(lat <= 2), 32'd1);
      issue(24'h000000, lat);
      check("s8_lat_wrap", 32'(lat <= 2), 32'd1);
      check("s8_wrap_rdata", 32'(rdata), 32'(rom_byte(24'h000000)));
      check("s8_no_cmd", 32'(falls), 32'(f0));

      // Randomized mix of sequential, repeated and scattered reads
      pa = 24'h000000;
      for (int i = 0; i < 80; i++) begin
         int m;
         m = $urandom_range(0, 9);
         if (m < 4)      na = pa + 24'd1;
         else if (m < 6) na = pa;
         else if (m < 8) na = 24'hFFFFF0 | 24'($urandom_range(0, 15));
         else            na = 24'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            req = 1'b0;
            repeat ($urandom_range(1, 12)) step();
         end
         issue(na, lat);
         pa = na;
      end
      req = 1'b0;
      repeat (12) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/qspi_rom_ctrl.md
QSPI_ROM_CTRL -- requirements
Module: qspi_rom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24: request/flash address width, a multiple of 4.
REQ-002 SHALL have parameter DUMMY_CYCLES, default 6: cycles between the last address nibble and the first data nibble.
REQ-003 SHALL have parameter IDLE_BYTES, default 4: unrequested streamed bytes tolerated before deselect.
REQ-004 SHALL use one clock and a synchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, 1, read request; held until rdata_valid.
REQ-007 SHALL have port addr, input, ADDR_BITS, byte address; stable while req is high.
REQ-008 SHALL have port rdata, output, 8, returned byte.
REQ-009 SHALL have port rdata_valid, output, 1, one-cycle pulse marking rdata for the current req.
REQ-010 SHALL have port qspi_cs_n, output, 1, flash select; high = deselected (drives the ROM model select).
REQ-011 SHALL have port qspi_io_out, output, 4, command/address nibble.
REQ-012 SHALL have port qspi_io_oe, output, 1, high while the controller drives IO.
REQ-013 SHALL have port qspi_io_in, input, 4, data nibble from flash.

Function
REQ-014 SHALL implement states IDLE, CMD, ADDR, DUMMY, STREAM, DESEL; all outputs registered.
REQ-015 IDLE + req + buffer miss -> CMD; qspi_cs_n low from the next cycle, called cycle 0.
REQ-016 CMD, cycles 0-7: opcode 0xEB MSB first, one bit per cycle; qspi_io_out = {1,1,0,bit}; qspi_io_oe=1.
REQ-017 ADDR, cycles 8..8+ADDR_BITS/4-1: addr MSB nibble first, latched at request acceptance; qspi_io_oe=1.
REQ-018 DUMMY: DUMMY_CYCLES cycles; qspi_io_oe=0, qspi_io_out=0.
REQ-019 STREAM: high nibble sampled at the edge ending cycle 20, low nibble at the edge ending cycle 21, then alternating; one byte per 2 cycles (ADDR_BITS=24, DUMMY_CYCLES=6).
REQ-020 Stream byte address B starts at the latched address, increments per completed byte, and wraps 2^ADDR_BITS-1 -> 0.
REQ-021 On completion of byte B with req=1 and addr==B: rdata=byte and rdata_valid=1 in the next cycle, and streaming continues.
REQ-022 Every completed byte SHALL load the prefetch buffer {last_addr=B, last_data, last_valid=1}.
REQ-023 If req=1, addr==last_addr and last_valid=1, in any state, the controller SHALL deliver last_data with rdata_valid in the next cycle; this buffer hit has priority over abort.
REQ-024 On completion of byte B with req=1 and addr not in {B, last_addr}: abort -> DESEL.
REQ-025 On completion with req=0: increment the idle counter; reaching IDLE_BYTES -> DESEL; any delivery clears the counter.
REQ-026 DESEL SHALL hold qspi_cs_n=1 for exactly 1 cycle, then go to IDLE, or to CMD if req is pending with a buffer miss.
REQ-027 A new request is accepted no earlier than the cycle after the rdata_valid of the previous request; rdata_valid SHALL never be high on consecutive cycles for the same request.
REQ-028 From IDLE, the latency from first req cycle to rdata_valid SHALL be 23 cycles; sequential hits while streaming complete within 2 cycles.

Reset
REQ-029 While reset=1 (at any clock edge, including mid-burst), the controller SHALL drive qspi_cs_n=1, qspi_io_oe=0, qspi_io_out=0, rdata=0, rdata_valid=0, last_valid=0, idle counter=0, state=IDLE.
REQ-030 The first request after reset SHALL start a full CMD sequence.

Structure
REQ-031 Package qspi_ctrl_pkg SHALL hold the state enum, the opcode 0xEB, the CMD length 8, and the IO idle nibble.
REQ-032 The prefetch buffer plus its hit compare SHALL be one sub-module, qspi_prefetch_buf; everything else stays flat.

Verification
REQ-033 Bench SHALL pair the DUT with the QSPI ROM model, with ROM[0xFFC]=0x00 and ROM[0xFFD]=0xF0.
REQ-034 Scenario: reset, then req addr=0x000FFC -> cs_n falls next cycle; io carries 0xEB bits then nibbles 0,0,0,F,F,C; rdata=0x00 after 23 cycles.
REQ-035 Scenario: after rdata_valid, req addr=0x000FFD -> rdata=0xF0 within 2 cycles with no cs_n rising edge.
REQ-036 Scenario: re-request 0x000FFD right after delivery -> buffer hit; rdata=0xF0 in the next cycle, ROM traffic undisturbed.
REQ-037 Scenario: while streaming, req addr=0x000100 -> abort; cs_n high exactly 1 cycle, new CMD/ADDR 0,0,0,1,0,0; ROM[0x100] returned.
REQ-038 Scenario: req=0 for 4 byte times -> cs_n high and IDLE; reset asserted mid-ADDR -> cs_n=1 and rdata_valid=0 next cycle.
